// File: rtl/dpram_arb_pkg.sv
// Shared defaults and priority encoding for the dual-port RAM front-end arbiter.
package dpram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

endpackage

// File: rtl/dpram_rr_prio.sv
// Same-address conflict detection and round-robin grant between requesters A and B.
module dpram_rr_prio
  import dpram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              coll
);

  logic prio_q, prio_d;

  always_comb begin
    coll   = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);
    a_gnt  = a_req;
    b_gnt  = b_req;
    prio_d = prio_q;
    if (coll) begin
      a_gnt  = (prio_q == PRIO_A);
      b_gnt  = (prio_q == PRIO_B);
      // Hand priority to whoever just lost so it wins the retry.
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares a dual-port RAM between requesters A and B; registers read data and counts collisions.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_data_1,
  output logic [DATA_W-1:0] ram_data_2,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [ADDR_W-1:0] ram_addr_2,
  output logic              ram_we_1,
  output logic              ram_we_2,
  input  logic [DATA_W-1:0] ram_q_1,
  input  logic [DATA_W-1:0] ram_q_2,
  output logic [CNT_W-1:0]  coll_cnt
);

  logic              coll;
  logic              a_rd, b_rd;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;

  dpram_rr_prio #(
    .ADDR_W (ADDR_W)
  ) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_req  (a_req),
    .a_we   (a_we),
    .a_addr (a_addr),
    .b_req  (b_req),
    .b_we   (b_we),
    .b_addr (b_addr),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt),
    .coll   (coll)
  );

  // A losing requester may still drive its address; only we is gated.
  assign ram_addr_1 = a_addr;
  assign ram_data_1 = a_wdata;
  assign ram_we_1   = a_gnt & a_we;
  assign ram_addr_2 = b_addr;
  assign ram_data_2 = b_wdata;
  assign ram_we_2   = b_gnt & b_we;

  assign a_rd = a_gnt & ~a_we;
  assign b_rd = b_gnt & ~b_we;

  always_comb begin
    a_rvalid_d = a_rd;
    b_rvalid_d = b_rd;
    a_rdata_d  = a_rd ? ram_q_1 : a_rdata_q;
    b_rdata_d  = b_rd ? ram_q_2 : b_rdata_q;
    coll_cnt_d = coll_cnt_q;
    if (coll && (coll_cnt_q != {CNT_W{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      coll_cnt_q <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 64x8 dual-port RAM attached.
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic [7:0]  ram_data_1, ram_data_2, ram_q_1, ram_q_2;
  logic [5:0]  ram_addr_1, ram_addr_2;
  logic        ram_we_1, ram_we_2;
  logic [15:0] coll_cnt;

  int n_checks = 0;
  int n_bad    = 0;
  int a_wins   = 0;
  int b_wins   = 0;

  logic [7:0] mem [64];

  always #5 clk = ~clk;

  dpram_port_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .ram_data_1 (ram_data_1),
    .ram_data_2 (ram_data_2),
    .ram_addr_1 (ram_addr_1),
    .ram_addr_2 (ram_addr_2),
    .ram_we_1   (ram_we_1),
    .ram_we_2   (ram_we_2),
    .ram_q_1    (ram_q_1),
    .ram_q_2    (ram_q_2),
    .coll_cnt   (coll_cnt)
  );

  // RAM: writes land at the edge; read data is presented for capture at the edge ending the cycle.
  always @(posedge clk) begin
    if (ram_we_1) mem[ram_addr_1] <= ram_data_1;
    if (ram_we_2) mem[ram_addr_2] <= ram_data_2;
  end
  assign ram_q_1 = mem[ram_addr_1];
  assign ram_q_2 = mem[ram_addr_2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [5:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [5:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    @(posedge clk); #1;
    check_eq("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    check_eq("rst_a_rdata", 32'(a_rdata), 32'd0);
    check_eq("rst_b_rdata", 32'(b_rdata), 32'd0);
    check_eq("rst_coll_cnt", 32'(coll_cnt), 32'd0);
    check_eq("idle_we1", 32'(ram_we_1), 32'd0);
    check_eq("idle_we2", 32'(ram_we_2), 32'd0);

    // Parallel disjoint writes
    @(negedge clk);
    drive(1'b1, 1'b1, 6'h01, 8'h42, 1'b1, 1'b1, 6'h02, 8'h55);
    #1;
    check_eq("dis_a_gnt", 32'(a_gnt), 32'd1);
    check_eq("dis_b_gnt", 32'(b_gnt), 32'd1);
    check_eq("dis_we1", 32'(ram_we_1), 32'd1);
    check_eq("dis_we2", 32'(ram_we_2), 32'd1);
    @(posedge clk); #1;
    check_eq("dis_wr_no_rvalid", 32'(a_rvalid), 32'd0);

    // Cross reads
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h02, 8'h00, 1'b1, 1'b0, 6'h01, 8'h00);
    #1;
    check_eq("xrd_we1_low", 32'(ram_we_1), 32'd0);
    @(posedge clk); #1;
    check_eq("xrd_a_rvalid", 32'(a_rvalid), 32'd1);
    check_eq("xrd_b_rvalid", 32'(b_rvalid), 32'd1);
    check_eq("xrd_a_rdata", 32'(a_rdata), 32'h55);
    check_eq("xrd_b_rdata", 32'(b_rdata), 32'h42);

    // Write/write collision at 0x03: A wins first, B retries
    @(negedge clk);
    drive(1'b1, 1'b1, 6'h03, 8'h57, 1'b1, 1'b1, 6'h03, 8'h99);
    #1;
    check_eq("ww1_a_gnt", 32'(a_gnt), 32'd1);
    check_eq("ww1_b_gnt", 32'(b_gnt), 32'd0);
    check_eq("ww1_we2", 32'(ram_we_2), 32'd0);
    @(posedge clk); #1;
    check_eq("ww1_cnt", 32'(coll_cnt), 32'd1);
    check_eq("ww1_rvalid_clr", 32'(a_rvalid), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h03, 8'h99);
    #1;
    check_eq("ww2_b_gnt", 32'(b_gnt), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h03, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    @(posedge clk); #1;
    check_eq("ww_rd_rvalid", 32'(a_rvalid), 32'd1);
    check_eq("ww_rd_data", 32'(a_rdata), 32'h99);
    check_eq("ww_cnt", 32'(coll_cnt), 32'd1);
    check_eq("ww_b_rdata_hold", 32'(b_rdata), 32'h42);

    // Reset so the fairness run starts with A holding priority and a zero counter
    @(negedge clk);
    drive(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst2_cnt", 32'(coll_cnt), 32'd0);

    // Sustained conflict at 0x10
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 6'h10, 8'(8'hA0 + i), 1'b1, 1'b1, 6'h10, 8'(8'hB0 + i));
      #1;
      check_eq("fair_a_gnt", 32'(a_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("fair_b_gnt", 32'(b_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (a_gnt) a_wins++;
      if (b_gnt) b_wins++;
      @(posedge clk);
    end
    #1;
    check_eq("fair_cnt", 32'(coll_cnt), 32'd8);
    check_eq("fair_a_wins", 32'(a_wins), 32'd4);
    check_eq("fair_b_wins", 32'(b_wins), 32'd4);
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h10, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    @(posedge clk); #1;
    check_eq("fair_last_data", 32'(a_rdata), 32'hB7);

    // Read/read same address is not a collision
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h01, 8'h00);
    #1;
    check_eq("rr_a_gnt", 32'(a_gnt), 32'd1);
    check_eq("rr_b_gnt", 32'(b_gnt), 32'd1);
    @(posedge clk); #1;
    check_eq("rr_a_rdata", 32'(a_rdata), 32'h42);
    check_eq("rr_b_rdata", 32'(b_rdata), 32'h42);
    check_eq("rr_b_rvalid", 32'(b_rvalid), 32'd1);
    check_eq("rr_cnt", 32'(coll_cnt), 32'd8);

    // Read/write collision, A reads and wins; then reset mid-conflict while B waits
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h05, 8'h00, 1'b1, 1'b1, 6'h05, 8'h77);
    #1;
    check_eq("rw_b_gnt", 32'(b_gnt), 32'd0);
    @(posedge clk); #1;
    check_eq("rw_a_rvalid", 32'(a_rvalid), 32'd1);
    check_eq("rw_cnt", 32'(coll_cnt), 32'd9);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("mid_rst_cnt", 32'(coll_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_a_gnt", 32'(a_gnt), 32'd1);
    check_eq("post_rst_b_gnt", 32'(b_gnt), 32'd0);
    @(posedge clk); #1;
    check_eq("post_rst_cnt", 32'(coll_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
